// File: rtl/bsg_async_fifo_pkg.sv
// Shared helpers for async FIFO pointer logic: Gray/binary conversion and parameter limits.
// Combinational only; no storage, no flow control.
package bsg_async_fifo_pkg;

    localparam int ptr_max_w_lp       = 9;
    localparam int lg_size_min_lp     = 1;
    localparam int lg_size_max_lp     = 8;
    localparam int sync_stages_min_lp = 2;
    localparam int sync_stages_max_lp = 4;

    typedef logic [ptr_max_w_lp-1:0] ptr_max_t;

    // Callers zero-extend narrower pointers; leading zeros do not disturb either conversion.
    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[ptr_max_w_lp-1] = gray[ptr_max_w_lp-1];
        for (int i = ptr_max_w_lp - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bsg_async_ptr_gray_wside_if.sv
// Write-side pointer bundle: producer request/ready plus pointer and status outputs.
// master = producer/environment, slave = pointer block.
interface bsg_async_ptr_gray_wside_if #(parameter int lg_size_p = 3);

    logic                 v_i;
    logic                 ready_o;
    logic [lg_size_p:0]   r_ptr_gray_i;
    logic [lg_size_p:0]   w_ptr_binary_r_o;
    logic [lg_size_p:0]   w_ptr_gray_r_o;
    logic [lg_size_p-1:0] w_addr_o;
    logic [lg_size_p:0]   r_ptr_binary_sync_o;
    logic                 full_o;
    logic [lg_size_p:0]   free_count_o;
    logic                 overflow_err_o;

    modport master (
        output v_i, r_ptr_gray_i,
        input  ready_o, w_ptr_binary_r_o, w_ptr_gray_r_o, w_addr_o,
               r_ptr_binary_sync_o, full_o, free_count_o, overflow_err_o
    );

    modport slave (
        input  v_i, r_ptr_gray_i,
        output ready_o, w_ptr_binary_r_o, w_ptr_gray_r_o, w_addr_o,
               r_ptr_binary_sync_o, full_o, free_count_o, overflow_err_o
    );

endinterface

// File: rtl/bsg_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded bus arriving from another clock domain.
// Latency: stages_p posedges; no backpressure, samples every cycle.
module bsg_sync_chain #(
    parameter int width_p  = 4,
    parameter int stages_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [stages_p-1:0][width_p-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[stages_p-2:0], d_i};
        end
    end

    assign q_o = sync_q[stages_p-1];

endmodule

// File: rtl/bsg_async_ptr_gray_wside.sv
// Async FIFO write-side pointer: binary/Gray write pointer, synchronised read pointer, full/free status.
// Latency: pointer updates next posedge; read-pointer changes seen after sync_stages_p posedges.
// Backpressure: ready_o low when full; v_i ignored while full.
module bsg_async_ptr_gray_wside
    import bsg_async_fifo_pkg::*;
#(
    parameter int lg_size_p     = 3,
    parameter int sync_stages_p = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_async_ptr_gray_wside_if.slave    bus
);

    typedef logic [lg_size_p:0] ptr_t;

    localparam ptr_t depth_c = ptr_t'(1 << lg_size_p);

    if (sync_stages_p < sync_stages_min_lp || sync_stages_p > sync_stages_max_lp) begin : g_bad_sync
        $error("sync_stages_p out of range");
    end
    if (lg_size_p < lg_size_min_lp || lg_size_p > lg_size_max_lp) begin : g_bad_lg
        $error("lg_size_p out of range");
    end

    ptr_t     w_bin_q, w_bin_d;
    ptr_t     w_gray_q, w_gray_d;
    ptr_t     r_gray_sync, r_bin_sync;
    ptr_t     occupancy;
    logic     ovf_q, ovf_d;
    logic     full, accept;
    ptr_max_t w_gray_ext, r_bin_ext;

    bsg_sync_chain #(
        .width_p  (lg_size_p + 1),
        .stages_p (sync_stages_p)
    ) u_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (bus.r_ptr_gray_i),
        .q_o       (r_gray_sync)
    );

    assign r_bin_ext  = gray2bin(ptr_max_t'(r_gray_sync));
    assign r_bin_sync = r_bin_ext[lg_size_p:0];

    // Status depends only on flops, so v_i never reaches full/ready/free combinationally.
    assign occupancy = w_bin_q - r_bin_sync;
    assign full      = (occupancy == depth_c);
    assign accept    = bus.v_i & ~full;

    assign w_bin_d    = accept ? w_bin_q + ptr_t'(1) : w_bin_q;
    assign w_gray_ext = bin2gray(ptr_max_t'(w_bin_d));
    assign w_gray_d   = w_gray_ext[lg_size_p:0];
    assign ovf_d      = ovf_q | (occupancy > depth_c);

    if (lg_size_p + 1 < ptr_max_w_lp) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^{w_gray_ext[ptr_max_w_lp-1:lg_size_p+1],
                             r_bin_ext[ptr_max_w_lp-1:lg_size_p+1]};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_bin_q  <= '0;
            w_gray_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            w_bin_q  <= w_bin_d;
            w_gray_q <= w_gray_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.w_ptr_binary_r_o    = w_bin_q;
    assign bus.w_ptr_gray_r_o      = w_gray_q;
    assign bus.w_addr_o            = w_bin_q[lg_size_p-1:0];
    assign bus.r_ptr_binary_sync_o = r_bin_sync;
    assign bus.full_o              = full;
    assign bus.ready_o             = ~full;
    assign bus.free_count_o        = depth_c - occupancy;
    assign bus.overflow_err_o      = ovf_q;

endmodule
